// File: rtl/rv_pkg.sv
// Shared RV32 opcode constants and the ID branch-resolution encoding
// used by the hazard/pipeline-control logic.
package rv_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] AMO    = 7'b0101111;

  // branch_id_s: 2'b11 is reserved and behaves like BR_NONE
  localparam logic [1:0] BR_NONE  = 2'b00;
  localparam logic [1:0] BR_TAKEN = 2'b01;
  localparam logic [1:0] BR_JALR  = 2'b10;

endpackage

// File: rtl/opcode_class_dec.sv
// Purely combinational opcode classifier: which source registers an
// instruction reads, whether it writes rd, loads from memory, or compares in ID.
module opcode_class_dec
  import rv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o,
  output logic       writes_rd_o,
  output logic       is_load_o,
  output logic       is_cmp_o
);

  always_comb begin
    uses_rs1_o = 1'b1;
    uses_rs2_o = 1'b1;
    case (opcode_i)
      LUI, AUIPC, JAL: begin
        uses_rs1_o = 1'b0;
        uses_rs2_o = 1'b0;
      end
      OP_IMM, LOAD, JALR: uses_rs2_o = 1'b0;
      default: ;
    endcase
    writes_rd_o = !((opcode_i == BRANCH) || (opcode_i == STORE));
    // AMOs return the old memory word into rd, so they hazard like loads
    is_load_o   = (opcode_i == LOAD) || (opcode_i == AMO);
    is_cmp_o    = (opcode_i == BRANCH) || (opcode_i == JALR);
  end

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard detection: shadows EX/MEM destination state, raises
// stall/flush controls and flags any stall run longer than MAX_STALL.
module hazard_unit
  import rv_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_STALL  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [6:0]            opcode,
  input  logic [1:0]            branch_id_s,
  output logic                  stall,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic                  stall_err
);

  localparam logic [1:0] STALL_LIMIT = 2'(MAX_STALL);

  logic                  uses_rs1, uses_rs2, writes_rd, is_load, is_cmp;

  logic                  id_valid_q, id_valid_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_wr_q, ex_wr_d;
  logic                  ex_ld_q, ex_ld_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  mem_ld_q, mem_ld_d;
  logic [1:0]            stall_cnt_q, stall_cnt_d;
  logic                  stall_err_q, stall_err_d;

  logic                  haz_rs1, haz_rs2;
  logic                  stall_raw, redirect, flush_raw;

  opcode_class_dec u_dec (
    .opcode_i    (opcode),
    .uses_rs1_o  (uses_rs1),
    .uses_rs2_o  (uses_rs2),
    .writes_rd_o (writes_rd),
    .is_load_o   (is_load),
    .is_cmp_o    (is_cmp)
  );

  // H1 load-use, H2 ALU result needed by an ID compare, H3 load two ahead of an ID compare
  function automatic logic src_hazard(input logic [REG_ADDR_W-1:0] rs, input logic used);
    logic h1, h2, h3;
    h1 = ex_ld_q && (rs == ex_rd_q);
    h2 = is_cmp && ex_wr_q && !ex_ld_q && (rs == ex_rd_q);
    h3 = is_cmp && mem_ld_q && (rs == mem_rd_q);
    return id_valid_q && used && (rs != '0) && (h1 || h2 || h3);
  endfunction

  always_comb begin
    haz_rs1   = src_hazard(rs1, uses_rs1);
    haz_rs2   = src_hazard(rs2, uses_rs2);
    stall_raw = haz_rs1 || haz_rs2;
    redirect  = (branch_id_s == BR_TAKEN) || (branch_id_s == BR_JALR);
    // a stalled instruction must not redirect; it retries once its operands arrive
    flush_raw = redirect && !stall_raw;
  end

  always_comb begin
    mem_rd_d = ex_rd_q;
    mem_ld_d = ex_ld_q;
    ex_rd_d  = rd;
    ex_wr_d  = writes_rd && id_valid_q;
    ex_ld_d  = is_load && id_valid_q;
    if (stall_raw) begin
      ex_wr_d = 1'b0;
      ex_ld_d = 1'b0;
    end
    id_valid_d = stall_raw ? id_valid_q : !flush_raw;
    if (!stall_raw) begin
      stall_cnt_d = 2'd0;
    end else if (stall_cnt_q == 2'd3) begin
      stall_cnt_d = 2'd3;
    end else begin
      stall_cnt_d = stall_cnt_q + 2'd1;
    end
    stall_err_d = stall_err_q || (stall_raw && (stall_cnt_q == STALL_LIMIT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid_q  <= 1'b0;
      ex_rd_q     <= '0;
      ex_wr_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      mem_rd_q    <= '0;
      mem_ld_q    <= 1'b0;
      stall_cnt_q <= 2'd0;
      stall_err_q <= 1'b0;
    end else begin
      id_valid_q  <= id_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_wr_q     <= ex_wr_d;
      ex_ld_q     <= ex_ld_d;
      mem_rd_q    <= mem_rd_d;
      mem_ld_q    <= mem_ld_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  // outputs are forced quiet for the whole reset window, including a live redirect
  always_comb begin
    stall     = stall_raw && !reset;
    flush_ex  = stall_raw && !reset;
    flush_id  = flush_raw && !reset;
    stall_err = stall_err_q && !reset;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- ID-stage hazard detection and pipeline-control block for the RV32IMA 5-stage core (IF, ID, EX, MEM, WB).
- Consumes the decoded ID-stage instruction fields and the ID branch-resolution code `branch_id_s`.
- Produces `stall`, `flush_id` and `flush_ex` for the PC/IF/ID registers and the ID/EX register.
- Keeps its own shadow copy of the EX and MEM destination/load state, and monitors stall length (at most 2 consecutive cycles).

Parameters:
- REG_ADDR_W, 5, register-address width.
- MAX_STALL, 2, maximum legal number of consecutive stall cycles.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- rs1  in  REG_ADDR_W  ID-stage rs1 field.
- rs2  in  REG_ADDR_W  ID-stage rs2 field.
- rd  in  REG_ADDR_W  ID-stage rd field.
- opcode  in  7  ID-stage opcode.
- branch_id_s  in  2  ID branch resolution: 00 none, 01 taken branch/JAL, 10 taken JALR, 11 treated as 00.
- stall  out  1  freeze PC and IF/ID.
- flush_id  out  1  kill the IF/ID register contents.
- flush_ex  out  1  insert a bubble into ID/EX.
- stall_err  out  1  sticky flag: stall exceeded MAX_STALL.

Behaviour:
- Single clock `clk`. Async active-high `reset` clears all state. While reset is high, stall=0, flush_id=0, flush_ex=0, stall_err=0.
- Opcode classes:
  - LOAD 0000011 and AMO 0101111 are "load" (rd written from memory).
  - rs1-only: OP-IMM 0010011, LOAD, JALR 1100111.
  - No rs: LUI 0110111, AUIPC 0010111, JAL 1101111.
  - All other opcodes use rs1 and rs2.
  - rd written by all opcodes except BRANCH 1100011 and STORE 0100011.
  - rd = x0 never creates a hazard.
- "ID compares" means opcode is BRANCH or JALR.
- State registers (all reset to 0):
  - id_valid.
  - ex_rd, ex_wr, ex_ld.
  - mem_rd, mem_ld.
  - stall_cnt (2 bits, saturating at 3).
  - stall_err.
- A hazard exists on rs_i when id_valid=1, rs_i is used by the opcode, and rs_i != 0. The three hazard conditions are:
  - H1, load-use: rs_i == ex_rd and ex_ld=1.
  - H2: ID compares, rs_i == ex_rd, ex_wr=1, ex_ld=0.
  - H3: ID compares, rs_i == mem_rd, mem_ld=1.
- Output equations (combinational from registered state and ID inputs; zero latency):
  - stall = H1 | H2 | H3.
  - flush_ex = stall.
  - flush_id = (branch_id_s is 01 or 10) & !stall. Stall has priority over a redirect.
- Register updates at each posedge:
  - mem <= ex.
  - If stall: ex <= bubble (wr=0, ld=0).
  - Otherwise: ex <= {rd, writes_rd & id_valid, is_load & id_valid}.
  - id_valid <= stall ? id_valid : !flush_id.
- Consequence of the id_valid update: the cycle after branch_id_s=01 or 10 with no stall, ID is invalid, so stall=0.
- Load followed by a dependent branch gives exactly 2 stall cycles: H1, then H3 after the bubble.
- stall_cnt:
  - Increments on each stall cycle (saturating at 3).
  - Clears to 0 on any cycle with stall=0.
- stall_err:
  - Set when stall=1 and stall_cnt == MAX_STALL.
  - Stays set until reset.
- Reset asserted mid-stall: all outputs drop to 0 immediately and all shadows clear. After reset deasserts, the first ID cycle is invalid.

Decomposition:
- Shared package `rv_pkg`: opcode localparams (LOAD, STORE, BRANCH, JALR, JAL, LUI, AUIPC, OP_IMM, OP, AMO) and the branch_id_s encoding constants.
- Natural sub-module: `opcode_class_dec`. Purely combinational; outputs uses_rs1, uses_rs2, writes_rd, is_load, is_cmp.
- Shadow registers, hazard logic and stall monitor stay in `hazard_unit`.

Test Plan:
- LOAD x5 then ADD x6,x5,x7 → exactly 1 cycle stall=1, flush_ex=1; ADD enters EX on the next cycle; stall_err=0.
- LOAD x5 then BEQ x5,x0 → stall=1 for exactly 2 consecutive cycles, then 0; stall_cnt peaks at 2; stall_err=0.
- ADDI x3 then BNE x3,x4 → 1 stall cycle (H2). With an independent BNE x8,x9 → no stall.
- BEQ with branch_id_s=01 → flush_id=1 that cycle; next cycle stall=0 even if opcode/rs1 match a load in EX.
- Stall cycle coinciding with branch_id_s=10 → flush_id=0 while stall=1; flush_id=1 on the first non-stall cycle.
- Forced 3-cycle stall (shadow regs preloaded via hierarchical force) → stall_err rises on the 3rd stall cycle and stays 1. Async reset mid-stall → all outputs 0 immediately, stall_err cleared.
